ptw_mem_responder: RTL and testbench
====================================

Name: ptw_mem_responder

Overview:
- Memory-side responder for the page-table-walk read interface driven by the address translater.
- Accepts each PTE read (translate_mem_enable + translate_addr) and issues one word read on the shared memory request/response bus.
- Returns the word on request_data with a single-cycle translate_data_valid pulse.
- Holds a one-entry cache of the most recent level-1 PTE, so consecutive walks in the same 4 MiB region skip one memory read.

Parameters:
- CACHE_EN, 1, enables the one-entry level-1 PTE cache; 0 means every request goes to memory.
- ADDR_W, 32, physical address width; fixed at 32 in this design.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- translate_mem_enable  input  1  walker request; held high for the whole walk.
- translate_addr  input  32  PTE word address; stable while a request is outstanding.
- request_data  output  32  returned PTE word.
- translate_data_valid  output  1  one-cycle pulse; request_data valid this cycle.
- flush_tlb  input  1  invalidates the PTE cache.
- mem_req_valid  output  1  memory read request.
- mem_req_ready  input  1  memory accepts the request this cycle.
- mem_req_addr  output  32  word-aligned read address.
- mem_resp_valid  input  1  read data returned.
- mem_resp_data  input  32  read data.
- busy  output  1  high whenever state != S_IDLE.

Behaviour:
- Reset (reset low, asynchronous) forces the following:
  - state S_IDLE.
  - All outputs 0.
  - Cache entry invalid.
  - prev_en 0, aborted 0.
- States: S_IDLE, S_REQ, S_WAIT, S_RESP.
- prev_en registers translate_mem_enable every cycle.
- A request is level-1 when it is accepted while prev_en==0, or in the first S_IDLE cycle after S_RESP only if prev_en==0. In practice: level-1 iff enable rose.
- S_IDLE:
  - If translate_mem_enable is high, capture req_addr = {translate_addr[31:2],2'b00} and level flag.
  - Cache hit (CACHE_EN, entry valid, level-1, req_addr == tag): load resp_data from the entry, go to S_RESP. Latency is accept + 1 cycle.
  - Otherwise go to S_REQ.
- S_REQ:
  - mem_req_valid=1, mem_req_addr=req_addr.
  - Stay until mem_req_ready, then go to S_WAIT.
  - The request may not be withdrawn once raised.
- S_WAIT:
  - On mem_resp_valid, latch mem_resp_data.
  - If aborted, go to S_IDLE with no pulse. Otherwise go to S_RESP.
  - mem_resp_valid is ignored outside S_WAIT. The bus guarantees the response arrives no earlier than the cycle after the handshake.
- S_RESP:
  - translate_data_valid=1 for exactly one cycle, then go to S_IDLE.
  - A new request is accepted on the very next S_IDLE cycle, which matches the walker advancing its address on the pulse cycle.
  - Back-to-back walk minimum: 1 idle cycle between responses.
- request_data holds its last value between pulses; it is 0 after reset.
- Abort:
  - translate_mem_enable low in S_REQ or S_WAIT sets aborted.
  - The memory transaction still completes; the data is discarded and the cache is not filled.
  - aborted clears on entry to S_IDLE.
  - Enable low in S_RESP: the pulse is still produced, which is harmless.
- Cache fill: on a memory response for a level-1 non-aborted request, tag := req_addr, data := response, valid := 1.
- Flush:
  - flush_tlb clears valid in the same cycle.
  - If flush_tlb was seen at any time during an outstanding level-1 miss, that fill is suppressed (flush_pending bit).
  - Flush and a fill in the same cycle: the flush wins.
- Level-0 requests never look up or fill the cache.

Decomposition:
- Shared package (ptw_pkg): state encodings S_IDLE..S_RESP, PTE word-alignment constant, ADDR_W.
- One natural sub-module: ptw_pte_cache (tag/data/valid registers, lookup compare, fill/flush/flush_pending logic).
- The FSM stays in ptw_mem_responder.

Test Plan:
- Miss walk: enable rises with addr 0x0000_1004. Memory is ready immediately and responds 3 cycles later with 0x0000_5001. Then the walker presents 0x0000_5010 and memory returns 0x0000_9001. Required response: two pulses carrying 0x0000_5001 then 0x0000_9001; mem_req_addr 0x0000_1004 then 0x0000_5010.
- Cache hit: repeat the walk with level-1 addr 0x0000_1004. Required response: no mem_req_valid for that level-1 request; pulse one cycle after accept with 0x0000_5001; level-0 still goes to memory.
- Flush: flush_tlb pulses between walks, then addr 0x0000_1004 again. Required response: memory read issued. Separately, flush during an outstanding level-1 miss leaves the entry invalid afterwards.
- Abort: drop enable while in S_WAIT, memory responds 0xDEAD_BEEF. Required response: no translate_data_valid, busy falls after the response, next walk to the same addr misses.
- Backpressure: mem_req_ready low for 5 cycles. Required response: mem_req_valid and mem_req_addr held stable; exactly one read; single pulse.
- Async reset: assert reset low in S_WAIT between clock edges. Required response: outputs 0 immediately; a stray mem_resp_valid after release is ignored; cache invalid.

Source files
------------

// File: rtl/ptw_pkg.sv
// Shared definitions for the page-table-walk memory responder:
// FSM state encoding, address width and PTE word alignment.
package ptw_pkg;

   localparam int PTW_ADDR_W = 32;

   // PTEs are 32-bit words, so the two low address bits never reach memory.
   localparam logic [PTW_ADDR_W-1:0] PTE_ALIGN_MASK = 32'h0000_0003;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } ptw_state_e;

   function automatic logic [PTW_ADDR_W-1:0] pte_align(input logic [PTW_ADDR_W-1:0] addr);
      return addr & ~PTE_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ptw_pte_cache.sv
// One-entry cache of the most recent level-1 PTE, with flush and
// suppression of a fill whose miss overlapped a flush.
module ptw_pte_cache
   import ptw_pkg::*;
#(
   parameter bit CACHE_EN = 1'b1,
   parameter int ADDR_W   = PTW_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] lookup_addr_i,
   output logic              hit_o,
   output logic [31:0]       hit_data_o,
   input  logic              miss_start_i,
   input  logic              fill_i,
   input  logic [ADDR_W-1:0] fill_addr_i,
   input  logic [31:0]       fill_data_i,
   input  logic              flush_i
);

   logic              valid_q, valid_d;
   logic              flush_pend_q, flush_pend_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic [31:0]       data_q, data_d;

   // A flush in the lookup cycle already counts as invalidating the entry.
   assign hit_o      = CACHE_EN && valid_q && !flush_i && (tag_q == lookup_addr_i);
   assign hit_data_o = data_q;

   always_comb begin
      valid_d      = valid_q;
      flush_pend_d = flush_pend_q;
      tag_d        = tag_q;
      data_d       = data_q;
      if (miss_start_i) begin
         flush_pend_d = 1'b0;
      end
      if (flush_i) begin
         valid_d      = 1'b0;
         flush_pend_d = 1'b1;
      end else if (CACHE_EN && fill_i && !flush_pend_q) begin
         valid_d = 1'b1;
         tag_d   = fill_addr_i;
         data_d  = fill_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/ptw_mem_responder.sv
// Memory-side responder for the page-table walker: turns each PTE read into
// one bus read (or a level-1 cache hit) and returns it with a one-cycle pulse.
module ptw_mem_responder
   import ptw_pkg::*;
#(
   parameter bit CACHE_EN = 1'b1,
   parameter int ADDR_W   = PTW_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              translate_mem_enable,
   input  logic [ADDR_W-1:0] translate_addr,
   output logic [31:0]       request_data,
   output logic              translate_data_valid,
   input  logic              flush_tlb,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_data,
   output logic              busy
);

   ptw_state_e        state_q, state_d;
   logic              prev_en_q;
   logic              aborted_q, aborted_d;
   logic              level1_q, level1_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;

   logic [ADDR_W-1:0] lookup_addr;
   logic              cache_hit;
   logic [31:0]       cache_data;
   logic              miss_start;
   logic              fill;
   logic              abort_now;

   assign lookup_addr = pte_align(translate_addr);

   ptw_pte_cache #(
      .CACHE_EN(CACHE_EN),
      .ADDR_W  (ADDR_W)
   ) u_cache (
      .clk          (clk),
      .rst_n        (reset),
      .lookup_addr_i(lookup_addr),
      .hit_o        (cache_hit),
      .hit_data_o   (cache_data),
      .miss_start_i (miss_start),
      .fill_i       (fill),
      .fill_addr_i  (req_addr_q),
      .fill_data_i  (mem_resp_data),
      .flush_i      (flush_tlb)
   );

   always_comb begin
      state_d    = state_q;
      aborted_d  = aborted_q;
      level1_d   = level1_q;
      data_d     = data_q;
      req_addr_d = req_addr_q;
      miss_start = 1'b0;
      fill       = 1'b0;
      abort_now  = aborted_q || !translate_mem_enable;

      unique case (state_q)
         S_IDLE: begin
            if (translate_mem_enable) begin
               req_addr_d = lookup_addr;
               level1_d   = !prev_en_q;
               if (!prev_en_q && cache_hit) begin
                  data_d  = cache_data;
                  state_d = S_RESP;
               end else begin
                  miss_start = !prev_en_q;
                  state_d    = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (!translate_mem_enable) aborted_d = 1'b1;
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!translate_mem_enable) aborted_d = 1'b1;
            // An abandoned read still drains from the bus but is dropped here.
            if (mem_resp_valid) begin
               if (abort_now) begin
                  state_d = S_IDLE;
               end else begin
                  data_d  = mem_resp_data;
                  fill    = level1_q;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_IDLE) aborted_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         prev_en_q <= 1'b0;
         aborted_q <= 1'b0;
         level1_q  <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         prev_en_q <= translate_mem_enable;
         aborted_q <= aborted_d;
         level1_q  <= level1_d;
         data_q    <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      req_addr_q <= req_addr_d;
   end

   assign translate_data_valid = (state_q == S_RESP);
   assign mem_req_valid        = (state_q == S_REQ);
   assign mem_req_addr         = mem_req_valid ? req_addr_q : '0;
   assign busy                 = (state_q != S_IDLE);
   assign request_data         = data_q;

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Randomized scoreboard bench for ptw_mem_responder with a bus memory model
// and an abstract model of the level-1 PTE cache.
module tb_ptw_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        translate_mem_enable;
   logic [31:0] translate_addr;
   logic [31:0] request_data;
   logic        translate_data_valid;
   logic        flush_tlb;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        busy;

   always #5 clk = ~clk;

   ptw_mem_responder dut (
      .clk                 (clk),
      .reset               (reset),
      .translate_mem_enable(translate_mem_enable),
      .translate_addr      (translate_addr),
      .request_data        (request_data),
      .translate_data_valid(translate_data_valid),
      .flush_tlb           (flush_tlb),
      .mem_req_valid       (mem_req_valid),
      .mem_req_ready       (mem_req_ready),
      .mem_req_addr        (mem_req_addr),
      .mem_resp_valid      (mem_resp_valid),
      .mem_resp_data       (mem_resp_data),
      .busy                (busy)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_data_q[$];
   logic [31:0] exp_addr_q[$];

   // Abstract cache model: the last completed level-1 address, unless flushed.
   bit          model_valid = 1'b0;
   logic [31:0] model_tag   = '0;

   // Memory model controls
   int          bp_cycles  = 0;
   int          force_lat  = 0;
   bit          rdy_always = 1'b0;
   bit          ovr_en     = 1'b0;
   logic [31:0] ovr_data   = '0;
   int          pend       = 0;
   logic [31:0] pend_data  = '0;
   int          n_reads    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_1004: return 32'h0000_5001;
         32'h0000_5010: return 32'h0000_9001;
         default:       return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
      endcase
   endfunction

   // Bus memory: random ready, response 1..4 cycles after the handshake.
   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = pend_data;
            end
         end
         if (bp_cycles > 0) begin
            mem_req_ready = 1'b0;
            bp_cycles--;
         end else if (rdy_always) begin
            mem_req_ready = 1'b1;
         end else begin
            mem_req_ready = ($urandom_range(3) != 0);
         end
         if (mem_req_valid) begin
            if (exp_addr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL mem_req_unexpected: read of 0x%08h issued, none expected", mem_req_addr);
            end else begin
               check("mem_req_addr", mem_req_addr, exp_addr_q[0]);
            end
            if (mem_req_ready) begin
               if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
               pend      = (force_lat > 0) ? force_lat : int'($urandom_range(4, 1));
               pend_data = ovr_en ? ovr_data : mem_word(mem_req_addr);
               ovr_en    = 1'b0;
               force_lat = 0;
               n_reads++;
            end
         end
      end
   end

   // Response monitor
   initial begin
      forever begin
         @(negedge clk);
         if (translate_data_valid) begin
            if (exp_data_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: request_data=0x%08h, no response expected", request_data);
            end else begin
               check("request_data", request_data, exp_data_q.pop_front());
            end
         end
      end
   end

   task automatic wait_pulse(input string name, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!translate_data_valid && cyc < 300);
      if (!translate_data_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no translate_data_valid within %0d cycles", name, cyc);
      end
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush_tlb = 1'b1;
      @(negedge clk);
      flush_tlb   = 1'b0;
      model_valid = 1'b0;
   endtask

   // One two-level walk; flush_at>0 pulses flush_tlb on that negedge after enable rises.
   task automatic do_walk(input logic [31:0] l1, input logic [31:0] l0, input int flush_at);
      logic [31:0] a1;
      logic [31:0] a0;
      bit          hit;
      int          cyc;
      a1  = l1 & ~32'h3;
      a0  = l0 & ~32'h3;
      hit = model_valid && (model_tag == a1);
      exp_data_q.push_back(mem_word(a1));
      if (!hit) exp_addr_q.push_back(a1);
      translate_addr       = l1;
      translate_mem_enable = 1'b1;
      if (flush_at > 0) begin
         for (int k = 1; k <= flush_at; k++) @(negedge clk);
         flush_tlb = 1'b1;
         @(negedge clk);
         flush_tlb = 1'b0;
      end
      wait_pulse("pulse_level1", cyc);
      if (hit) check("hit_latency", cyc, 1);
      exp_data_q.push_back(mem_word(a0));
      exp_addr_q.push_back(a0);
      translate_addr = l0;
      wait_pulse("pulse_level0", cyc);
      translate_mem_enable = 1'b0;
      if (flush_at > 0) begin
         model_valid = 1'b0;
      end else if (!hit) begin
         model_valid = 1'b1;
         model_tag   = a1;
      end
      repeat ($urandom_range(3, 1)) @(negedge clk);
   endtask

   initial begin
      int          cyc;
      int          reads0;
      logic [31:0] pool[4];
      logic [31:0] l1;

      reset                = 1'b0;
      translate_mem_enable = 1'b0;
      translate_addr       = '0;
      flush_tlb            = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", translate_data_valid, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_req_addr", mem_req_addr, 0);
      check("rst_request_data", request_data, 0);
      reset = 1'b1;
      @(negedge clk);

      // Miss walk with immediate ready
      rdy_always = 1'b1;
      force_lat  = 3;
      do_walk(32'h0000_1004, 32'h0000_5010, 0);
      rdy_always = 1'b0;

      // Level-1 hit, level-0 still to memory
      do_walk(32'h0000_1004, 32'h0000_5010, 0);

      // Flush between walks forces a re-read
      do_flush();
      do_walk(32'h0000_1004, 32'h0000_5010, 0);

      // Flush while the level-1 miss waits for data: entry stays invalid
      @(negedge clk);
      rdy_always = 1'b1;
      force_lat  = 3;
      do_walk(32'h0000_2008, 32'h0000_2100, 2);
      rdy_always = 1'b0;
      do_walk(32'h0000_2008, 32'h0000_2100, 0);
      do_walk(32'h0000_2008, 32'h0000_2104, 0);

      // Abort in S_WAIT
      rdy_always = 1'b1;
      force_lat  = 4;
      ovr_en     = 1'b1;
      ovr_data   = 32'hDEAD_BEEF;
      @(negedge clk);
      exp_addr_q.push_back(32'h0000_7ABC);
      translate_addr       = 32'h0000_7ABC;
      translate_mem_enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      translate_mem_enable = 1'b0;
      @(negedge clk);
      check("abort_busy_held", busy, 1);
      cyc = 3;
      while (busy && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_busy_fall_cycle", cyc, 6);
      rdy_always = 1'b0;
      do_walk(32'h0000_7ABC, 32'h0000_7AC0, 0);

      // Backpressure on the level-1 read
      reads0    = n_reads;
      bp_cycles = 6;
      do_walk(32'h0000_3000, 32'h0000_3040, 0);
      check("bp_read_count", n_reads - reads0, 2);

      // Randomized walks
      pool[0] = 32'h0000_1004;
      pool[1] = 32'h0000_2008;
      pool[2] = 32'h0000_3000;
      for (int i = 0; i < 25; i++) begin
         pool[3] = 32'h0004_0000 | ($urandom & 32'h0000_FFFC);
         l1 = pool[$urandom_range(3)] | 32'($urandom_range(3));
         if ($urandom_range(4) == 0) do_flush();
         do_walk(l1, $urandom & 32'h00FF_FFFF, 0);
      end

      // Asynchronous reset while waiting for memory
      rdy_always = 1'b1;
      force_lat  = 4;
      @(negedge clk);
      exp_addr_q.push_back(32'h0000_B000);
      translate_addr       = 32'h0000_B000;
      translate_mem_enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_mem_req_valid", mem_req_valid, 0);
      check("arst_valid", translate_data_valid, 0);
      check("arst_request_data", request_data, 0);
      translate_mem_enable = 1'b0;
      @(negedge clk);
      reset       = 1'b1;
      model_valid = 1'b0;
      rdy_always  = 1'b0;
      repeat (3) @(negedge clk);
      check("arst_stray_busy", busy, 0);
      check("arst_stray_request_data", request_data, 0);
      do_walk(32'h0000_1004, 32'h0000_5010, 0);

      repeat (5) @(negedge clk);
      check("exp_data_drained", exp_data_q.size(), 0);
      check("exp_addr_drained", exp_addr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
